// File: rtl/keypad_display_pkg.sv
// Shared types and constants for the keypad scanner and 7-segment display unit.
package keypad_display_pkg;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_e;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [3:0] column_drive(input col_state_e s);
        logic [3:0] drive;
        case (s)
            COL0:    drive = 4'b1110;
            COL1:    drive = 4'b1101;
            COL2:    drive = 4'b1011;
            default: drive = 4'b0111;
        endcase
        return drive;
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input col_state_e col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = KEY_A;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = KEY_B;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = KEY_C;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = KEY_HASH;
            default:  code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_display_unit_seg7_decoder.sv
// BCD nibble to active-low 7-segment pattern; non-decimal values blank the digit.
module seg7_decoder
    import keypad_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/keypad_display_unit.sv
// 4x4 keypad column scanner with row debounce and key strobe, plus a
// 3-digit multiplexed 7-segment driver for the BCD result.
module keypad_display_unit
    import keypad_display_pkg::*;
#(
    parameter int SCAN_DIV        = 27000,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int REFRESH_DIV     = 27000
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [3:0]  filas_raw,
    input  logic [11:0] cdu,
    output logic [3:0]  columnas,
    output logic [3:0]  sample,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [2:0]  a,
    output logic [6:0]  d
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int REF_W  = $clog2(REFRESH_DIV);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [REF_W-1:0]  REF_ONE   = REF_W'(1);

    function automatic logic [1:0] lowest_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (rows[0])      idx = 2'd0;
        else if (rows[1]) idx = 2'd1;
        else if (rows[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

    logic [3:0]        row_meta;
    logic [3:0]        row_sync;
    logic [DB_W-1:0]   db_cnt  [4];
    logic [DB_W-1:0]   db_next [4];
    logic [3:0]        sample_next;
    logic              accept;
    logic              busy;
    col_state_e        state;
    logic [SCAN_W-1:0] scan_cnt;
    logic [REF_W-1:0]  ref_cnt;
    logic [1:0]        dig_sel;
    logic [3:0]        nibble;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= ~filas_raw;
            row_sync <= row_meta;
        end
    end

    // A row only flips after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_comb begin
        sample_next = sample;
        for (int i = 0; i < 4; i++) begin
            db_next[i] = '0;
            if (row_sync[i] != sample[i]) begin
                if (db_cnt[i] == DB_LAST) sample_next[i] = row_sync[i];
                else                      db_next[i] = db_cnt[i] + DB_ONE;
            end
        end
    end

    assign accept = (sample == 4'b0000) && (sample_next != 4'b0000);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sample    <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sample    <= sample_next;
            key_valid <= accept;
            if (accept) key_code <= key_lookup(lowest_row(sample_next), state);
            for (int i = 0; i < 4; i++) db_cnt[i] <= db_next[i];
        end
    end

    // A row is only seen during its own column window, so the scan must
    // stop as soon as activity reaches the synchronizer, not only once the
    // (much slower) debounced sample confirms it.
    assign busy = (sample != 4'b0000) || (row_sync != 4'b0000);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= COL0;
            scan_cnt <= '0;
        end else if (busy) begin
            scan_cnt <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            case (state)
                COL0:    state <= COL1;
                COL1:    state <= COL2;
                COL2:    state <= COL3;
                default: state <= COL0;
            endcase
        end else begin
            scan_cnt <= scan_cnt + SCAN_ONE;
        end
    end

    assign columnas = column_drive(state);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ref_cnt <= '0;
            dig_sel <= 2'd0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            dig_sel <= (dig_sel == 2'd2) ? 2'd0 : dig_sel + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + REF_ONE;
        end
    end

    assign a = ~(3'b001 << dig_sel);

    always_comb begin
        case (dig_sel)
            2'd0:    nibble = cdu[3:0];
            2'd1:    nibble = cdu[7:4];
            default: nibble = cdu[11:8];
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .digit (nibble),
        .seg   (d)
    );

endmodule

// File: tb/tb_keypad_display_unit.sv
// Bench for keypad_display_unit with small divider parameters and a keypad matrix model.
module tb_keypad_display_unit;

    logic        clk;
    logic        n_reset;
    logic [3:0]  filas_raw;
    logic [11:0] cdu;
    logic [3:0]  columnas;
    logic [3:0]  sample;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [2:0]  a;
    logic [6:0]  d;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    logic       press;
    logic [1:0] prow;
    logic [1:0] pcol;
    logic [3:0] force_rows;
    logic [3:0] kmap [16];
    logic [3:0] exp_q [$];

    typedef struct {
        logic [3:0] col;
        logic [2:0] an;
        logic [6:0] seg;
    } vec_t;
    vec_t tbl [12];

    keypad_display_unit #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (3),
        .REFRESH_DIV     (2)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .filas_raw (filas_raw),
        .cdu       (cdu),
        .columnas  (columnas),
        .sample    (sample),
        .key_code  (key_code),
        .key_valid (key_valid),
        .a         (a),
        .d         (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low only while its column is driven.
    always_comb begin
        filas_raw = ~force_rows;
        if (press && (columnas[pcol] == 1'b0)) filas_raw[prow] = 1'b0;
    end

    always @(negedge clk) begin
        if (n_reset && key_valid) begin
            logic [3:0] want;
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL key_strobe unexpected code=%0d", key_code);
            end else begin
                want = exp_q.pop_front();
                if (key_code !== want) begin
                    errors++;
                    $display("FAIL key_strobe got=%0d want=%0d", key_code, want);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic wait_col_entry(input logic [3:0] target);
        logic [3:0] prev;
        bit hit;
        prev = columnas;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (columnas == target && prev != target) hit = 1'b1;
            prev = columnas;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_col got=%b want=%b", columnas, target);
        end
    endtask

    task automatic wait_units;
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (a == 3'b110) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_units got=%b want=110", a);
        end
    endtask

    initial begin
        int n_before;
        kmap = '{4'd1, 4'd2, 4'd3, 4'd10,
                 4'd4, 4'd5, 4'd6, 4'd11,
                 4'd7, 4'd8, 4'd9, 4'd12,
                 4'd14, 4'd0, 4'd15, 4'd13};
        // cdu = 407: units 7, tens 0, hundreds 4
        tbl[0]  = '{4'b1110, 3'b110, 7'b1111000};
        tbl[1]  = '{4'b1110, 3'b110, 7'b1111000};
        tbl[2]  = '{4'b1110, 3'b101, 7'b1000000};
        tbl[3]  = '{4'b1110, 3'b101, 7'b1000000};
        tbl[4]  = '{4'b1101, 3'b011, 7'b0011001};
        tbl[5]  = '{4'b1101, 3'b011, 7'b0011001};
        tbl[6]  = '{4'b1101, 3'b110, 7'b1111000};
        tbl[7]  = '{4'b1101, 3'b110, 7'b1111000};
        tbl[8]  = '{4'b1011, 3'b101, 7'b1000000};
        tbl[9]  = '{4'b1011, 3'b101, 7'b1000000};
        tbl[10] = '{4'b1011, 3'b011, 7'b0011001};
        tbl[11] = '{4'b1011, 3'b011, 7'b0011001};

        n_reset    = 1'b0;
        press      = 1'b0;
        prow       = 2'd0;
        pcol       = 2'd0;
        force_rows = 4'b0000;
        cdu        = 12'h407;

        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (7) @(negedge clk);

        // Asynchronous reset between edges
        @(posedge clk);
        #3 n_reset = 1'b0;
        #1;
        check("rst_columnas", 16'(columnas), 16'(4'b1110));
        check("rst_a", 16'(a), 16'(3'b110));
        check("rst_sample", 16'(sample), 16'h0);
        check("rst_key_valid", 16'(key_valid), 16'h0);
        check("rst_key_code", 16'(key_code), 16'h0);

        @(negedge clk);
        n_reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("scan_col_%0d", k), 16'(columnas), 16'(tbl[k].col));
            check($sformatf("disp_a_%0d", k), 16'(a), 16'(tbl[k].an));
            check($sformatf("disp_d_%0d", k), 16'(d), 16'(tbl[k].seg));
            @(negedge clk);
        end

        // Key "5": row1 on column 1
        wait_col_entry(4'b1101);
        prow = 2'd1;
        pcol = 2'd1;
        exp_q.push_back(kmap[5]);
        press = 1'b1;
        repeat (4) @(negedge clk);
        check("k5_sample_early", 16'(sample), 16'h0);
        check("k5_valid_early", 16'(key_valid), 16'h0);
        @(negedge clk);
        check("k5_sample", 16'(sample), 16'(4'b0010));
        check("k5_valid", 16'(key_valid), 16'h1);
        check("k5_code", 16'(key_code), 16'd5);
        repeat (10) @(negedge clk);
        check("k5_frozen", 16'(columnas), 16'(4'b1101));
        check("k5_valid_after", 16'(key_valid), 16'h0);
        press = 1'b0;
        wait_col_entry(4'b1011);
        check("k5_released", 16'(sample), 16'h0);

        // Bouncing row0 must never be accepted
        n_before = strobes;
        for (int i = 0; i < 10; i++) begin
            force_rows[0] = ~force_rows[0];
            @(negedge clk);
        end
        force_rows[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("bounce_sample", 16'(sample), 16'h0);
        check("bounce_strobes", 16'(strobes), 16'(n_before));

        wait_col_entry(4'b1110);
        exp_q.push_back(kmap[0]);
        force_rows[0] = 1'b1;
        repeat (8) @(negedge clk);
        check("hold_sample", 16'(sample), 16'(4'b0001));
        check("hold_code", 16'(key_code), 16'd1);
        check("hold_strobes", 16'(strobes), 16'(n_before + 1));
        force_rows[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("hold_released", 16'(sample), 16'h0);

        // Blank digit and combinational cdu path
        cdu = 12'h00C;
        wait_units();
        check("blank_d", 16'(d), 16'(7'b1111111));
        cdu = 12'h003;
        #1;
        check("cdu_comb_d", 16'(d), 16'(7'b0110000));

        // Key "#": row3 on column 2
        wait_col_entry(4'b1011);
        prow = 2'd3;
        pcol = 2'd2;
        exp_q.push_back(kmap[14]);
        press = 1'b1;
        repeat (6) @(negedge clk);
        check("khash_code", 16'(key_code), 16'd15);
        check("khash_sample", 16'(sample), 16'(4'b1000));
        press = 1'b0;
        repeat (12) @(negedge clk);

        // Held key across a mid-operation reset is accepted again
        wait_col_entry(4'b1110);
        prow = 2'd2;
        pcol = 2'd0;
        exp_q.push_back(kmap[8]);
        press = 1'b1;
        repeat (6) @(negedge clk);
        check("k7_code", 16'(key_code), 16'd7);
        @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("mid_rst_sample", 16'(sample), 16'h0);
        check("mid_rst_code", 16'(key_code), 16'h0);
        check("mid_rst_columnas", 16'(columnas), 16'(4'b1110));
        check("mid_rst_a", 16'(a), 16'(3'b110));
        @(negedge clk);
        n_reset = 1'b1;
        exp_q.push_back(kmap[8]);
        repeat (6) @(negedge clk);
        check("k7_again_code", 16'(key_code), 16'd7);
        check("k7_again_sample", 16'(sample), 16'(4'b0100));
        press = 1'b0;
        repeat (10) @(negedge clk);

        check("queue_empty", 16'(exp_q.size()), 16'h0);
        check("strobe_total", 16'(strobes), 16'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
